// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/FLUSH/DONE control of instruction fetch,
// with stall, halt and PC-relative branches, plus a saturating executed-instruction count.
module pc_sequencer #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [D-1:0]  Start_addr,
  input  logic          Stall,
  input  logic          Branch_en,
  input  logic          Branch_taken,
  input  logic [D-1:0]  Target,
  input  logic          Halt,
  output logic [D-1:0]  Prog_ctr,
  output logic          Fetch_valid,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Instr_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc_s;

  // Saturating increment of the executed-instruction count.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Next-state logic; in RUN the priority is stall, halt, taken branch, sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = Start_addr;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (Stall) begin
          state_d = S_RUN;
        end else if (Halt) begin
          state_d = S_DONE;
          cnt_d   = cnt_inc_s;
        end else if (Branch_en && Branch_taken) begin
          // Same-width add gives sign-extended offset modulo 2^D.
          state_d = S_FLUSH;
          pc_d    = pc_q + Target;
          cnt_d   = cnt_inc_s;
        end else begin
          pc_d    = pc_q + PC_ONE;
          cnt_d   = cnt_inc_s;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = {D{1'b0}};
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, program counter and instruction count registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= {D{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Prog_ctr    = pc_q;
  assign Instr_cnt   = cnt_q;
  assign Fetch_valid = (state_q == S_RUN);
  assign Busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign Done        = (state_q == S_DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; a second instance with a 3-bit counter covers saturation.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [11:0] Start_addr;
  logic        Stall;
  logic        Branch_en;
  logic        Branch_taken;
  logic [11:0] Target;
  logic        Halt;
  logic [11:0] Prog_ctr;
  logic        Fetch_valid;
  logic        Busy;
  logic        Done;
  logic [15:0] Instr_cnt;
  logic [11:0] sat_pc;
  logic        sat_fv;
  logic        sat_busy;
  logic        sat_done;
  logic [2:0]  sat_cnt;

  int checks;
  int errors;

  pc_sequencer #(.D(12), .CW(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Start_addr(Start_addr),
    .Stall(Stall), .Branch_en(Branch_en), .Branch_taken(Branch_taken),
    .Target(Target), .Halt(Halt), .Prog_ctr(Prog_ctr), .Fetch_valid(Fetch_valid),
    .Busy(Busy), .Done(Done), .Instr_cnt(Instr_cnt)
  );

  pc_sequencer #(.D(12), .CW(3)) dut_sat (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Start_addr(Start_addr),
    .Stall(Stall), .Branch_en(Branch_en), .Branch_taken(Branch_taken),
    .Target(Target), .Halt(Halt), .Prog_ctr(sat_pc), .Fetch_valid(sat_fv),
    .Busy(sat_busy), .Done(sat_done), .Instr_cnt(sat_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] addr);
    Start = 1'b1; Start_addr = addr;
    step();
    Start = 1'b0;
  endtask

  task automatic do_halt();
    Halt = 1'b1;
    step();
    Halt = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; Start_addr = 12'h000; Stall = 1'b0;
    Branch_en = 1'b0; Branch_taken = 1'b0; Target = 12'h000; Halt = 1'b0;
    #2;
    checks++; if (Prog_ctr !== 12'h000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", Prog_ctr, 12'h000); end
    checks++; if (Instr_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", Instr_cnt); end
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {Fetch_valid, Busy, Done}); end
    step();
    Reset_n = 1'b1;
    step();
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b000) begin errors++; $display("FAIL idle_flags got=%b exp=000", {Fetch_valid, Busy, Done}); end
  endtask

  task automatic test_sequential();
    do_start(12'h010);
    checks++; if (Prog_ctr !== 12'h010) begin errors++; $display("FAIL seq_start_pc got=%h exp=%h", Prog_ctr, 12'h010); end
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b110) begin errors++; $display("FAIL seq_run_flags got=%b exp=110", {Fetch_valid, Busy, Done}); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (Prog_ctr !== 12'h010 + 12'(i)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, Prog_ctr, 12'h010 + 12'(i)); end
    end
    checks++; if (Instr_cnt !== 16'd3) begin errors++; $display("FAIL seq_cnt got=%0d exp=3", Instr_cnt); end
    checks++; if (Fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv got=%b exp=1", Fetch_valid); end
    do_start(12'h3AA);
    checks++; if (Prog_ctr !== 12'h014) begin errors++; $display("FAIL start_ignored_pc got=%h exp=%h", Prog_ctr, 12'h014); end
    do_halt();
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b001) begin errors++; $display("FAIL halt_flags got=%b exp=001", {Fetch_valid, Busy, Done}); end
    checks++; if (Prog_ctr !== 12'h014 || Instr_cnt !== 16'd5) begin errors++; $display("FAIL halt_pc_cnt got=%h/%0d exp=014/5", Prog_ctr, Instr_cnt); end
  endtask

  task automatic test_branch();
    do_start(12'h020);
    Branch_en = 1'b1; Branch_taken = 1'b1; Target = 12'hF9B;
    step();
    Branch_en = 1'b0; Branch_taken = 1'b0; Target = 12'h000;
    checks++; if (Prog_ctr !== 12'hFBB) begin errors++; $display("FAIL br_pc got=%h exp=%h", Prog_ctr, 12'hFBB); end
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b010) begin errors++; $display("FAIL br_flush_flags got=%b exp=010", {Fetch_valid, Busy, Done}); end
    checks++; if (Instr_cnt !== 16'd1) begin errors++; $display("FAIL br_cnt got=%0d exp=1", Instr_cnt); end
    Halt = 1'b1; Stall = 1'b1; Branch_en = 1'b1; Branch_taken = 1'b1; Target = 12'h005;
    step();
    Halt = 1'b0; Stall = 1'b0; Branch_en = 1'b0; Branch_taken = 1'b0; Target = 12'h000;
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b110) begin errors++; $display("FAIL br_resume_flags got=%b exp=110", {Fetch_valid, Busy, Done}); end
    checks++; if (Prog_ctr !== 12'hFBB || Instr_cnt !== 16'd1) begin errors++; $display("FAIL br_resume got=%h/%0d exp=fbb/1", Prog_ctr, Instr_cnt); end
    do_halt();
  endtask

  task automatic test_stall_halt();
    do_start(12'h005);
    Stall = 1'b1; Halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (Prog_ctr !== 12'h005 || Instr_cnt !== 16'd0 || Fetch_valid !== 1'b1) begin
        errors++; $display("FAIL stall%0d got=%h/%0d/%b exp=005/0/1", i, Prog_ctr, Instr_cnt, Fetch_valid);
      end
    end
    Stall = 1'b0;
    step();
    Halt = 1'b0;
    checks++; if (Done !== 1'b1 || Prog_ctr !== 12'h005 || Instr_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_halt got=%b/%h/%0d exp=1/005/1", Done, Prog_ctr, Instr_cnt);
    end
    step();
    checks++; if (Done !== 1'b1 || Fetch_valid !== 1'b0 || Instr_cnt !== 16'd1) begin
      errors++; $display("FAIL done_hold got=%b/%b/%0d exp=1/0/1", Done, Fetch_valid, Instr_cnt);
    end
  endtask

  task automatic test_wrap();
    do_start(12'hFFE);
    step();
    checks++; if (Prog_ctr !== 12'hFFF) begin errors++; $display("FAIL wrap_fff got=%h exp=fff", Prog_ctr); end
    Branch_en = 1'b1;
    step();
    checks++; if (Prog_ctr !== 12'h000 || Fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_000 got=%h/%b exp=000/1", Prog_ctr, Fetch_valid); end
    Branch_en = 1'b0; Branch_taken = 1'b1;
    step();
    checks++; if (Prog_ctr !== 12'h001 || Fetch_valid !== 1'b1) begin errors++; $display("FAIL taken_alone got=%h/%b exp=001/1", Prog_ctr, Fetch_valid); end
    Branch_en = 1'b1; Target = 12'h000;
    step();
    Branch_en = 1'b0; Branch_taken = 1'b0;
    checks++; if (Prog_ctr !== 12'h001 || {Fetch_valid, Busy} !== 2'b01) begin errors++; $display("FAIL br_zero got=%h/%b exp=001/01", Prog_ctr, {Fetch_valid, Busy}); end
    step();
    checks++; if (Prog_ctr !== 12'h001 || Fetch_valid !== 1'b1 || Instr_cnt !== 16'd4) begin
      errors++; $display("FAIL br_zero_resume got=%h/%b/%0d exp=001/1/4", Prog_ctr, Fetch_valid, Instr_cnt);
    end
    do_halt();
  endtask

  task automatic test_saturation();
    do_start(12'h200);
    for (int i = 0; i < 9; i++) step();
    checks++; if (Instr_cnt !== 16'd9) begin errors++; $display("FAIL sat_wide_cnt got=%0d exp=9", Instr_cnt); end
    checks++; if (sat_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt got=%0d exp=7", sat_cnt); end
    checks++; if (sat_pc !== 12'h209 || {sat_fv, sat_busy} !== 2'b11) begin errors++; $display("FAIL sat_pc got=%h/%b exp=209/11", sat_pc, {sat_fv, sat_busy}); end
    do_halt();
    checks++; if (sat_cnt !== 3'd7 || sat_done !== 1'b1) begin errors++; $display("FAIL sat_halt got=%0d/%b exp=7/1", sat_cnt, sat_done); end
  endtask

  task automatic test_restart();
    do_start(12'h030);
    for (int i = 0; i < 6; i++) step();
    do_halt();
    checks++; if (Instr_cnt !== 16'd7 || Done !== 1'b1) begin errors++; $display("FAIL restart_pre got=%0d/%b exp=7/1", Instr_cnt, Done); end
    do_start(12'h040);
    checks++; if (Prog_ctr !== 12'h040 || Instr_cnt !== 16'd0) begin errors++; $display("FAIL restart got=%h/%0d exp=040/0", Prog_ctr, Instr_cnt); end
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b110) begin errors++; $display("FAIL restart_flags got=%b exp=110", {Fetch_valid, Busy, Done}); end
  endtask

  task automatic test_reset_flush();
    Branch_en = 1'b1; Branch_taken = 1'b1; Target = 12'h010;
    step();
    Branch_en = 1'b0; Branch_taken = 1'b0; Target = 12'h000;
    checks++; if (Prog_ctr !== 12'h050 || {Fetch_valid, Busy} !== 2'b01) begin errors++; $display("FAIL pre_rst_flush got=%h/%b exp=050/01", Prog_ctr, {Fetch_valid, Busy}); end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (Prog_ctr !== 12'h000 || Instr_cnt !== 16'd0) begin errors++; $display("FAIL async_rst got=%h/%0d exp=000/0", Prog_ctr, Instr_cnt); end
    checks++; if ({Fetch_valid, Busy, Done} !== 3'b000) begin errors++; $display("FAIL async_rst_flags got=%b exp=000", {Fetch_valid, Busy, Done}); end
    #2;
    Reset_n = 1'b1;
    do_start(12'h100);
    checks++; if (Prog_ctr !== 12'h100 || Fetch_valid !== 1'b1 || Instr_cnt !== 16'd0) begin
      errors++; $display("FAIL post_rst_start got=%h/%b/%0d exp=100/1/0", Prog_ctr, Fetch_valid, Instr_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_halt();
    test_wrap();
    test_saturation();
    test_restart();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
